// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: operand forwarding, single-cycle ALU,
// iterative shift-add multiplier that stalls the front end, and registered MEM-stage outputs.
module ex_mem_stage #(
  parameter int MUL_STEP_BITS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  ALUOp_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic        Mem2Reg_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] imm_i,
  input  logic [9:0]  funct_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [1:0]  fwdA_i,
  input  logic [1:0]  fwdB_i,
  input  logic [31:0] exmem_fwd_i,
  input  logic [31:0] memwb_fwd_i,
  output logic        stall_o,
  output logic [31:0] ALUres_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemWrite_o,
  output logic        MemRead_o,
  output logic        Mem2Reg_o
);

  localparam int         N        = 32 / MUL_STEP_BITS;
  localparam logic [4:0] CNT_LAST = 5'(N - 1);

  localparam logic [9:0] F_ADD = 10'b0000000_000;
  localparam logic [9:0] F_SUB = 10'b0100000_000;
  localparam logic [9:0] F_AND = 10'b0000000_111;
  localparam logic [9:0] F_OR  = 10'b0000000_110;
  localparam logic [9:0] F_MUL = 10'b0000001_000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] prod_q, prod_d;

  logic [31:0] alures_q, alures_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rdaddr_q, rdaddr_d;
  logic        regwrite_q, regwrite_d;
  logic        memwrite_q, memwrite_d;
  logic        memread_q, memread_d;
  logic        mem2reg_q, mem2reg_d;

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] step_sum;
  logic        is_mul;
  logic        stall;

  // Encoding 11 deliberately falls back to the ID_EX value.
  always_comb begin
    case (fwdA_i)
      2'b10:   op_a = exmem_fwd_i;
      2'b01:   op_a = memwb_fwd_i;
      default: op_a = RSdata_i;
    endcase
    case (fwdB_i)
      2'b10:   fwd_b = exmem_fwd_i;
      2'b01:   fwd_b = memwb_fwd_i;
      default: fwd_b = RTdata_i;
    endcase
    op_b = ALUSrc_i ? imm_i : fwd_b;
  end

  assign is_mul = (ALUOp_i == 2'b10) && (funct_i == F_MUL);

  always_comb begin
    alu_res = '0;
    case (ALUOp_i)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (funct_i)
          F_ADD:   alu_res = op_a + op_b;
          F_SUB:   alu_res = op_a - op_b;
          F_AND:   alu_res = op_a & op_b;
          F_OR:    alu_res = op_a | op_b;
          default: alu_res = '0;
        endcase
      end
      default: begin
        case (funct_i[2:0])
          3'b000:  alu_res = op_a + op_b;
          3'b101:  alu_res = $signed(op_a) >>> imm_i[4:0];
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // One partial product per multiplier bit retired this cycle.
  logic [31:0] partial [MUL_STEP_BITS];
  generate
    for (genvar gi = 0; gi < MUL_STEP_BITS; gi++) begin : g_partial
      assign partial[gi] = mplier_q[gi] ? (mcand_q << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < MUL_STEP_BITS; i++) begin
      step_sum = step_sum + partial[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        prod_d   = prod_q + step_sum;
        mcand_d  = mcand_q << MUL_STEP_BITS;
        mplier_d = mplier_q >> MUL_STEP_BITS;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with rst_i lets the stall drop the moment reset is asserted.
  assign stall   = rst_i && (((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY));
  assign stall_o = stall;

  always_comb begin
    alures_d   = '0;
    wdata_d    = '0;
    rdaddr_d   = '0;
    regwrite_d = 1'b0;
    memwrite_d = 1'b0;
    memread_d  = 1'b0;
    mem2reg_d  = 1'b0;
    if (!stall) begin
      alures_d   = (state_q == S_DONE) ? prod_q : alu_res;
      wdata_d    = fwd_b;
      rdaddr_d   = RDaddr_i;
      regwrite_d = RegWrite_i;
      memwrite_d = MemWrite_i;
      memread_d  = MemRead_i;
      mem2reg_d  = Mem2Reg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      alures_q   <= '0;
      wdata_q    <= '0;
      rdaddr_q   <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      mem2reg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      alures_q   <= alures_d;
      wdata_q    <= wdata_d;
      rdaddr_q   <= rdaddr_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memread_q  <= memread_d;
      mem2reg_q  <= mem2reg_d;
    end
  end

  assign ALUres_o   = alures_q;
  assign wdata_o    = wdata_q;
  assign RDaddr_o   = rdaddr_q;
  assign RegWrite_o = regwrite_q;
  assign MemWrite_o = memwrite_q;
  assign MemRead_o  = memread_q;
  assign Mem2Reg_o  = mem2reg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for single-cycle ops, hand sequences for
// the iterative multiplier (two step widths), back-to-back MUL and reset during a MUL.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alu_op, alu_op4;
  logic        alu_src;
  logic        rw_i, mw_i, mr_i, m2r_i;
  logic [31:0] rs, rt, imm;
  logic [9:0]  funct;
  logic [4:0]  rd;
  logic [1:0]  fwda, fwdb;
  logic [31:0] exf, mwf;

  logic        stall, d4_stall;
  logic [31:0] res, d4_res, wdata, d4_wdata;
  logic [4:0]  rd_o, d4_rd_o;
  logic        rw_o, mw_o, mr_o, m2r_o;
  logic        d4_rw_o, d4_mw_o, d4_mr_o, d4_m2r_o;

  int tests;
  int failed;

  ex_mem_stage dut (
    .clk_i(clk), .rst_i(rst_n), .ALUOp_i(alu_op), .ALUSrc_i(alu_src),
    .RegWrite_i(rw_i), .MemWrite_i(mw_i), .MemRead_i(mr_i), .Mem2Reg_i(m2r_i),
    .RSdata_i(rs), .RTdata_i(rt), .imm_i(imm), .funct_i(funct), .RDaddr_i(rd),
    .fwdA_i(fwda), .fwdB_i(fwdb), .exmem_fwd_i(exf), .memwb_fwd_i(mwf),
    .stall_o(stall), .ALUres_o(res), .wdata_o(wdata), .RDaddr_o(rd_o),
    .RegWrite_o(rw_o), .MemWrite_o(mw_o), .MemRead_o(mr_o), .Mem2Reg_o(m2r_o)
  );

  ex_mem_stage #(.MUL_STEP_BITS(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .ALUOp_i(alu_op4), .ALUSrc_i(alu_src),
    .RegWrite_i(rw_i), .MemWrite_i(mw_i), .MemRead_i(mr_i), .Mem2Reg_i(m2r_i),
    .RSdata_i(rs), .RTdata_i(rt), .imm_i(imm), .funct_i(funct), .RDaddr_i(rd),
    .fwdA_i(fwda), .fwdB_i(fwdb), .exmem_fwd_i(exf), .memwb_fwd_i(mwf),
    .stall_o(d4_stall), .ALUres_o(d4_res), .wdata_o(d4_wdata), .RDaddr_o(d4_rd_o),
    .RegWrite_o(d4_rw_o), .MemWrite_o(d4_mw_o), .MemRead_o(d4_mr_o), .Mem2Reg_o(d4_m2r_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [3:0]  ctrl;      // {RegWrite, MemWrite, MemRead, Mem2Reg}
    logic [31:0] rs, rt, imm;
    logic [9:0]  funct;
    logic [4:0]  rd;
    logic [1:0]  fwda, fwdb;
    logic [31:0] exf, mwf;
    logic [31:0] exp_res, exp_wdata;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] op, logic src, logic [3:0] ctrl,
                               logic [31:0] a, logic [31:0] b, logic [31:0] im,
                               logic [9:0] fn, logic [4:0] d, logic [1:0] fa, logic [1:0] fb,
                               logic [31:0] ef, logic [31:0] mf,
                               logic [31:0] er, logic [31:0] ew);
    vec_t v;
    v.alu_op = op; v.alu_src = src; v.ctrl = ctrl;
    v.rs = a; v.rt = b; v.imm = im; v.funct = fn; v.rd = d;
    v.fwda = fa; v.fwdb = fb; v.exf = ef; v.mwf = mf;
    v.exp_res = er; v.exp_wdata = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic src, input logic [3:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [9:0] fn, input logic [4:0] d, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] ef, input logic [31:0] mf);
    alu_op = op; alu_src = src;
    {rw_i, mw_i, mr_i, m2r_i} = ctrl;
    rs = a; rt = b; imm = im; funct = fn; rd = d;
    fwda = fa; fwdb = fb; exf = ef; mwf = mf;
  endtask

  task automatic drive_nop();
    drive(2'b00, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 10'd0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    alu_op4 = 2'b00;
  endtask

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? stall : d4_stall;
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    return (sel == 0) ? res : d4_res;
  endfunction

  function automatic logic [31:0] get_side(input int sel);
    return (sel == 0) ? {wdata[26:0] | 27'd0, rd_o} | {31'd0, rw_o | mw_o | mr_o | m2r_o}
                      : {d4_wdata[26:0] | 27'd0, d4_rd_o} | {31'd0, d4_rw_o | d4_mw_o | d4_mr_o | d4_m2r_o};
  endfunction

  // Called just after a rising edge; issues a MUL and follows it to write-back into EX/MEM.
  // With perturb set, operand A comes through exmem forwarding that changes mid-multiply.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int sel, input int exp_stall,
                        input bit perturb);
    int n, bub, g;
    if (perturb)
      drive(2'b10, 1'b0, 4'b1000, 32'hDEAD0000, b, 32'd0, 10'b0000001_000, 5'd15,
            2'b10, 2'b00, a, 32'd0);
    else
      drive(2'b10, 1'b0, 4'b1000, a, b, 32'd0, 10'b0000001_000, 5'd15,
            2'b00, 2'b00, 32'd0, 32'd0);
    if (sel == 1) begin
      alu_op4 = 2'b10;
      alu_op  = 2'b00;
    end
    #1;
    n = 0; bub = 0; g = 0;
    while (get_stall(sel) && g < 200) begin
      n++;
      @(posedge clk); #1;
      if (get_res(sel) !== 32'd0 || get_side(sel) !== 32'd0) bub++;
      if (perturb && n == 3) begin
        exf = exf + 32'd100;
        rs  = 32'h12345678;
      end
      g++;
    end
    chk({tag, "_timeout"}, (g < 200) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_bubbles"}, bub, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_result"}, get_res(sel), exp);
    chk({tag, "_rd_regwrite"}, (sel == 0) ? {26'd0, rd_o, rw_o} : {26'd0, d4_rd_o, d4_rw_o},
        {26'd0, 5'd15, 1'b1});
  endtask

  vec_t vecs [13];

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    alu_op4 = 2'b00;

    vecs[0]  = mkv(2'b10, 0, 4'b1000, 32'd5, 32'd7, 32'd0, 10'h000, 5'd3, 2'b00, 2'b00, 0, 0, 32'd12, 32'd7);
    vecs[1]  = mkv(2'b10, 0, 4'b1000, 32'h99, 32'h77, 32'd0, 10'h100, 5'd4, 2'b10, 2'b01, 32'h10, 32'd3, 32'h0000000D, 32'd3);
    vecs[2]  = mkv(2'b10, 0, 4'b1000, 32'hF0F0, 32'hFF00, 32'd0, 10'h007, 5'd5, 2'b00, 2'b00, 0, 0, 32'hF000, 32'hFF00);
    vecs[3]  = mkv(2'b10, 0, 4'b1000, 32'hF0F0, 32'h0F0F, 32'd0, 10'h006, 5'd6, 2'b00, 2'b00, 0, 0, 32'hFFFF, 32'h0F0F);
    vecs[4]  = mkv(2'b11, 1, 4'b1000, 32'h80000000, 32'd0, 32'd4, 10'h105, 5'd7, 2'b00, 2'b00, 0, 0, 32'hF8000000, 32'd0);
    vecs[5]  = mkv(2'b00, 1, 4'b0100, 32'h100, 32'hDEADBEEF, 32'd8, 10'h002, 5'd0, 2'b00, 2'b00, 0, 0, 32'h108, 32'hDEADBEEF);
    vecs[6]  = mkv(2'b01, 0, 4'b1000, 32'd10, 32'd20, 32'd0, 10'h000, 5'd8, 2'b00, 2'b00, 0, 0, 32'hFFFFFFF6, 32'd20);
    vecs[7]  = mkv(2'b10, 0, 4'b1000, 32'd5, 32'd7, 32'd0, 10'h001, 5'd9, 2'b00, 2'b00, 0, 0, 32'd0, 32'd7);
    vecs[8]  = mkv(2'b11, 1, 4'b1000, 32'd100, 32'd0, 32'hFFFFFFFF, 10'h000, 5'd10, 2'b00, 2'b00, 0, 0, 32'd99, 32'd0);
    vecs[9]  = mkv(2'b10, 0, 4'b1000, 32'd1, 32'd2, 32'd0, 10'h000, 5'd11, 2'b11, 2'b11, 32'h1000, 32'h2000, 32'd3, 32'd2);
    vecs[10] = mkv(2'b00, 1, 4'b1011, 32'h200, 32'h55, 32'hFFFFFFFC, 10'h002, 5'd12, 2'b00, 2'b00, 0, 0, 32'h1FC, 32'h55);
    vecs[11] = mkv(2'b10, 0, 4'b1000, 32'd9, 32'd9, 32'd0, 10'h000, 5'd31, 2'b10, 2'b10, 32'h40000000, 0, 32'h80000000, 32'h40000000);
    vecs[12] = mkv(2'b11, 1, 4'b1000, 32'd77, 32'd1, 32'd3, 10'h002, 5'd13, 2'b00, 2'b00, 0, 0, 32'd0, 32'd1);

    // Reset holding a MUL in ID_EX: nothing may stall or leak out.
    drive(2'b10, 1'b0, 4'b1111, 32'd3, 32'd3, 32'd1, 10'b0000001_000, 5'd1, 2'b00, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_rd_ctrl", {23'd0, rd_o, rw_o, mw_o, mr_o, m2r_o}, 32'd0);
    drive_nop();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].alu_op, vecs[i].alu_src, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].imm,
            vecs[i].funct, vecs[i].rd, vecs[i].fwda, vecs[i].fwdb, vecs[i].exf, vecs[i].mwf);
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_rd", i), {27'd0, rd_o}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_ctrl", i), {28'd0, rw_o, mw_o, mr_o, m2r_o}, {28'd0, vecs[i].ctrl});
      $display("[TB] vec%0d res=0x%08h wdata=0x%08h", i, res, wdata);
      drive_nop();
    end

    @(posedge clk); #1;
    do_mul("mul_7x6", 32'd7, 32'd6, 32'd42, 0, 33, 1'b0);
    $display("[TB] mul 7*6 res=0x%08h", res);
    do_mul("mul_b2b", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0, 33, 1'b0);
    $display("[TB] mul ffffffff*2 res=0x%08h", res);
    do_mul("mul_fwd_latched", 32'd4, 32'd5, 32'd20, 0, 33, 1'b1);
    $display("[TB] mul fwd 4*5 res=0x%08h", res);
    drive_nop();

    @(posedge clk); #1;
    do_mul("mul4_ffff_x2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1, 9, 1'b0);
    $display("[TB] mul4 ffffffff*2 res=0x%08h", d4_res);
    do_mul("mul4_7x6", 32'd7, 32'd6, 32'd42, 1, 9, 1'b0);
    $display("[TB] mul4 7*6 res=0x%08h", d4_res);
    drive_nop();

    // Reset at BUSY cnt=10 (11 edges after the MUL enters EX).
    @(posedge clk); #1;
    drive(2'b10, 1'b0, 4'b1000, 32'd5, 32'd5, 32'd0, 10'b0000001_000, 5'd15, 2'b00, 2'b00, 0, 0);
    repeat (11) @(posedge clk);
    #1;
    chk("midrst_busy_stall", {31'd0, stall}, 32'd1);
    chk("midrst_dut4_busy_out", d4_res, 32'd10);
    rst_n = 1'b0;
    drive(2'b10, 1'b0, 4'b1000, 32'd3, 32'd3, 32'd0, 10'b0000001_000, 5'd15, 2'b00, 2'b00, 0, 0);
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_res", res, 32'd0);
    chk("midrst_dut4_res", d4_res, 32'd0);
    chk("midrst_dut4_ctrl", {23'd0, d4_rd_o, d4_rw_o, d4_mw_o, d4_mr_o, d4_m2r_o}, 32'd0);
    $display("[TB] reset mid-mul stall=%0b res=0x%08h", stall, res);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_mul("mul_after_rst", 32'd3, 32'd3, 32'd9, 0, 33, 1'b0);
    $display("[TB] mul 3*3 after reset res=0x%08h", res);
    drive_nop();
    @(posedge clk); #1;
    chk("final_nop_stall", {31'd0, stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
